// File: rtl/ghost_collision_monitor.sv
// Pacman-vs-ghost proximity detector: one squared-distance check per cycle over a per-frame snapshot, plus lives tracking.
// Define COLLISION_INVULN_EN to grant INVULN_FRAMES frames of invulnerability after each life loss.
module ghost_collision_monitor #(
  parameter int NUM_GHOSTS    = 3,
  parameter int COORD_W       = 10,
  parameter int RADIUS_SQ     = 64,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  localparam int LIVES_W      = $clog2(LIVES + 1)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_clk,
  input  logic [COORD_W-1:0]            pacmanX,
  input  logic [COORD_W-1:0]            pacmanY,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghostX,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghostY,
  output logic [NUM_GHOSTS-1:0]         hit_mask,
  output logic                          life_lost,
  output logic [LIVES_W-1:0]            lives,
  output logic                          isDefeated,
  output logic                          busy
);

  localparam int IDX_W  = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int DIST_W = 2 * COORD_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

  logic [1:0]                    state;
  logic                          fc_q;
  logic                          frame_edge;
  logic [COORD_W-1:0]            snap_px;
  logic [COORD_W-1:0]            snap_py;
  logic [NUM_GHOSTS*COORD_W-1:0] snap_gx;
  logic [NUM_GHOSTS*COORD_W-1:0] snap_gy;
  logic [IDX_W-1:0]              idx;
  logic [NUM_GHOSTS-1:0]         scratch;
  logic [COORD_W-1:0]            cur_gx;
  logic [COORD_W-1:0]            cur_gy;
  logic [COORD_W-1:0]            dx;
  logic [COORD_W-1:0]            dy;
  logic [DIST_W-1:0]             dist_sq;
  logic                          hit;
  logic                          hit_now;
  logic                          loss;

`ifdef COLLISION_INVULN_EN
  localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  logic [INV_W-1:0] invuln_cnt;
`else
  logic hit_prev;
`endif

  assign frame_edge = frame_clk && !fc_q;

  // Evaluation reads only the snapshot, so ghosts moving mid-scan cannot disturb it.
  assign cur_gx  = snap_gx[int'(idx)*COORD_W +: COORD_W];
  assign cur_gy  = snap_gy[int'(idx)*COORD_W +: COORD_W];
  assign dx      = (snap_px >= cur_gx) ? (snap_px - cur_gx) : (cur_gx - snap_px);
  assign dy      = (snap_py >= cur_gy) ? (snap_py - cur_gy) : (cur_gy - snap_py);
  assign dist_sq = DIST_W'(dx) * DIST_W'(dx) + DIST_W'(dy) * DIST_W'(dy);
  assign hit     = dist_sq < DIST_W'(RADIUS_SQ);

  assign hit_now = |scratch;

`ifdef COLLISION_INVULN_EN
  assign loss = hit_now && (invuln_cnt == '0) && (lives != '0);
`else
  assign loss = hit_now && !hit_prev && (lives != '0);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      fc_q      <= 1'b0;
      snap_px   <= '0;
      snap_py   <= '0;
      snap_gx   <= '0;
      snap_gy   <= '0;
      idx       <= '0;
      scratch   <= '0;
      hit_mask  <= '0;
      life_lost <= 1'b0;
      lives     <= LIVES_W'(LIVES);
`ifdef COLLISION_INVULN_EN
      invuln_cnt <= '0;
`else
      hit_prev  <= 1'b0;
`endif
    end else begin
      fc_q      <= frame_clk;
      life_lost <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_edge) begin
            snap_px <= pacmanX;
            snap_py <= pacmanY;
            snap_gx <= ghostX;
            snap_gy <= ghostY;
            idx     <= '0;
            scratch <= '0;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          scratch[idx] <= hit;
          if (idx == LAST_IDX) begin
            state <= ST_RESOLVE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_RESOLVE: begin
          hit_mask <= scratch;
          if (loss) begin
            lives     <= lives - LIVES_W'(1);
            life_lost <= 1'b1;
          end
`ifdef COLLISION_INVULN_EN
          // The counter runs in frames, so it only moves on RESOLVE.
          if (loss) begin
            invuln_cnt <= INV_W'(INVULN_FRAMES);
          end else if (invuln_cnt != '0) begin
            invuln_cnt <= invuln_cnt - INV_W'(1);
          end
`else
          hit_prev <= hit_now;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign isDefeated = (lives == '0);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ghost_collision_monitor.sv
// Scoreboard bench for ghost_collision_monitor: a default 3-ghost instance and an 8-ghost, single-life instance.
// Expectations come from an integer distance model and a lives model that follows COLLISION_INVULN_EN.
module tb_ghost_collision_monitor;

  typedef struct {
    int mask;
    int lives;
    int lost;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        fc_a;
  logic [9:0]  pax, pay;
  logic [29:0] gxa, gya;
  logic [2:0]  mask_a;
  logic        lost_a, def_a, busy_a;
  logic [1:0]  lives_a;

  logic        fc_b;
  logic [9:0]  pbx, pby;
  logic [79:0] gxb, gyb;
  logic [7:0]  mask_b;
  logic        lost_b, def_b, busy_b;
  logic [0:0]  lives_b;

  int   passes = 0;
  int   total  = 0;
  exp_t sb[$];

  int   s_px, s_py;
  int   s_gx[8];
  int   s_gy[8];

  int   ng[2] = '{3, 8};
  int   m_lives[2];
  bit   m_prev[2];
  int   m_inv[2];

  always #5 clk = ~clk;

  ghost_collision_monitor dut_a (
    .Clk(clk), .Reset(reset), .frame_clk(fc_a),
    .pacmanX(pax), .pacmanY(pay), .ghostX(gxa), .ghostY(gya),
    .hit_mask(mask_a), .life_lost(lost_a), .lives(lives_a),
    .isDefeated(def_a), .busy(busy_a)
  );

  ghost_collision_monitor #(.NUM_GHOSTS(8), .LIVES(1)) dut_b (
    .Clk(clk), .Reset(reset), .frame_clk(fc_b),
    .pacmanX(pbx), .pacmanY(pby), .ghostX(gxb), .ghostY(gyb),
    .hit_mask(mask_b), .life_lost(lost_b), .lives(lives_b),
    .isDefeated(def_b), .busy(busy_b)
  );

  function automatic bit is_hit(input int ax, input int ay, input int bx, input int by);
    int ddx, ddy;
    ddx = ax - bx;
    ddy = ay - by;
    return (ddx * ddx + ddy * ddy) < 64;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic modelReset();
    m_lives = '{3, 1};
    m_prev  = '{1'b0, 1'b0};
    m_inv   = '{0, 0};
  endtask

  task automatic farGhosts();
    for (int i = 0; i < 8; i++) begin
      s_gx[i] = 700 + i * 30;
      s_gy[i] = 50;
    end
  endtask

  task automatic driveCoords(input int sel, input bit scramble);
    logic [9:0] vx, vy;
    for (int i = 0; i < 8; i++) begin
      vx = scramble ? 10'd512 : 10'(s_gx[i]);
      vy = scramble ? 10'd512 : 10'(s_gy[i]);
      if (sel == 0 && i < 3) begin
        gxa[i*10 +: 10] = vx;
        gya[i*10 +: 10] = vy;
      end
      if (sel == 1) begin
        gxb[i*10 +: 10] = vx;
        gyb[i*10 +: 10] = vy;
      end
    end
    vx = scramble ? 10'd512 : 10'(s_px);
    vy = scramble ? 10'd512 : 10'(s_py);
    if (sel == 0) begin
      pax = vx;
      pay = vy;
    end else begin
      pbx = vx;
      pby = vy;
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    fc_a  = 1'b0;
    fc_b  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic checkOutput(input int sel);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    check("hit_mask", sel ? 32'(mask_b) : 32'(mask_a), e.mask);
    check("lives", sel ? 32'(lives_b) : 32'(lives_a), e.lives);
    check("life_lost", sel ? 32'(lost_b) : 32'(lost_a), e.lost);
    check("isDefeated", sel ? 32'(def_b) : 32'(def_a), (e.lives == 0) ? 1 : 0);
    check("busy_done", sel ? 32'(busy_b) : 32'(busy_a), 0);
  endtask

  // One frame: predict, push, run the scan with the inputs scrambled after the snapshot, then compare.
  task automatic applyStimulus(input int sel, input bit reedge);
    exp_t e;
    int   m;
    bit   hn, loss;
    m = 0;
    for (int i = 0; i < ng[sel]; i++)
      if (is_hit(s_px, s_py, s_gx[i], s_gy[i])) m |= (1 << i);
    hn = (m != 0);
`ifdef COLLISION_INVULN_EN
    loss = hn && (m_inv[sel] == 0) && (m_lives[sel] != 0);
    if (loss) m_inv[sel] = 60;
    else if (m_inv[sel] > 0) m_inv[sel]--;
`else
    loss = hn && !m_prev[sel] && (m_lives[sel] != 0);
`endif
    m_prev[sel] = hn;
    if (loss) m_lives[sel]--;
    e.mask  = m;
    e.lives = m_lives[sel];
    e.lost  = loss ? 1 : 0;
    sb.push_back(e);

    driveCoords(sel, 1'b0);
    if (sel == 0) fc_a = 1'b1;
    else fc_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_edge0", sel ? 32'(busy_b) : 32'(busy_a), 1);
    driveCoords(sel, 1'b1);
    for (int c = 1; c <= ng[sel]; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (reedge && c == 2) fc_b = 1'b0;
      if (reedge && c == 3) fc_b = 1'b1;
    end
    check("busy_before_resolve", sel ? 32'(busy_b) : 32'(busy_a), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput(sel);
    @(posedge clk);
    @(negedge clk);
    check("life_lost_width", sel ? 32'(lost_b) : 32'(lost_a), 0);
    check("no_restart", sel ? 32'(busy_b) : 32'(busy_a), 0);
    if (sel == 0) fc_a = 1'b0;
    else fc_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    fc_a  = 1'b0;
    fc_b  = 1'b0;
    pax = '0; pay = '0; gxa = '0; gya = '0;
    pbx = '0; pby = '0; gxb = '0; gyb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();

    check("rst_hit_mask", 32'(mask_a), 0);
    check("rst_life_lost", 32'(lost_a), 0);
    check("rst_lives", 32'(lives_a), 3);
    check("rst_isDefeated", 32'(def_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_lives_b", 32'(lives_b), 1);

    $display("[TB] single hit on ghost 1");
    farGhosts();
    s_px = 105; s_py = 103;
    s_gx[1] = 100; s_gy[1] = 100;
    applyStimulus(0, 1'b0);

    $display("[TB] threshold: dist^2 == 64 misses");
    farGhosts();
    s_px = 200; s_py = 200;
    s_gx[0] = 208; s_gy[0] = 200;
    s_gx[1] = 600; s_gy[1] = 600;
    s_gx[2] = 10;  s_gy[2] = 10;
    applyStimulus(0, 1'b0);

    $display("[TB] threshold: dist^2 == 58 hits, no wraparound");
    s_px = 0; s_py = 0;
    s_gx[0] = 1023; s_gy[0] = 0;
    s_gx[1] = 0;    s_gy[1] = 1023;
    s_gx[2] = 7;    s_gy[2] = 3;
    applyStimulus(0, 1'b0);

    $display("[TB] reset mid-scan");
    farGhosts();
    s_px = 300; s_py = 300;
    s_gx[0] = 301; s_gy[0] = 302;
    driveCoords(0, 1'b0);
    fc_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    fc_a  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_lives", 32'(lives_a), 3);
    check("midrst_hit_mask", 32'(mask_a), 0);
    check("midrst_life_lost", 32'(lost_a), 0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 1'b0);

    $display("[TB] persistent overlap for 100 frames");
    pulseReset();
    farGhosts();
    s_px = 400; s_py = 400;
    s_gx[0] = 402; s_gy[0] = 401;
    for (int f = 0; f < 100; f++) applyStimulus(0, 1'b0);
`ifdef COLLISION_INVULN_EN
    check("persist_final_lives", 32'(lives_a), 1);
`else
    check("persist_final_lives", 32'(lives_a), 2);
`endif

    $display("[TB] 8 ghosts all overlapping, second edge while busy");
    s_px = 500; s_py = 500;
    for (int i = 0; i < 8; i++) begin
      s_gx[i] = 500 + (i % 3);
      s_gy[i] = 502 - (i % 2);
    end
    applyStimulus(1, 1'b1);

    $display("[TB] game over: hits no longer cost lives");
    farGhosts();
    s_px = 500; s_py = 500;
    for (int i = 0; i < 4; i++) begin
      s_gx[i] = 503;
      s_gy[i] = 500 + i;
    end
    applyStimulus(1, 1'b0);
    check("gameover_lives", 32'(lives_b), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/ghost_collision_monitor.md
# ghost_collision_monitor

Parametrised pacman-vs-ghost proximity detector and life tracker. It generalises the fixed three-ghost, combinational "any distance < 64" defeat check to NUM_GHOSTS ghosts. Once per frame it snapshots the coordinates and scans the ghosts one per cycle through a single squared-distance datapath. It owns the lives counter, with optional post-hit invulnerability. It sits in the top level between the sprite movers (pacman, ghost_*) and color_mapper, and drives `isDefeated`.

## Interface
Parameters:
- NUM_GHOSTS, 3: number of ghost channels, 1..16.
- COORD_W, 10: coordinate width in bits.
- RADIUS_SQ, 64: collision threshold on squared distance. A hit is dist² < RADIUS_SQ.
- LIVES, 3: initial lives, ≥1.
- INVULN_FRAMES, 60: frames of invulnerability after a life loss. Used only with COLLISION_INVULN_EN.

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50).
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame strobe (VGA_VS), synchronous to Clk; the rising edge starts a scan.
- pacmanX, pacmanY  in  COORD_W each  pacman centre.
- ghostX, ghostY  in  NUM_GHOSTS*COORD_W each  packed ghost centres; ghost i occupies bits [i*COORD_W +: COORD_W].
- hit_mask  out  NUM_GHOSTS  per-ghost hit result of the last completed scan.
- life_lost  out  1  one-cycle pulse when a life is deducted.
- lives  out  $clog2(LIVES+1)  remaining lives.
- isDefeated  out  1  level; high when lives == 0.
- busy  out  1  high while a scan is in progress (SCAN or RESOLVE).

## Operation
- Edge detect: frame_clk is registered into fc_q. A frame edge is frame_clk && !fc_q.
- FSM with three states: IDLE, SCAN, RESOLVE.
  - IDLE: on a frame edge, capture pacmanX/Y and all ghostX/Y into snapshot registers, clear the scan index and scratch mask, and go to SCAN.
  - SCAN: each cycle, evaluate ghost[idx] from the snapshot and write the result to scratch[idx].
    - dx = |px − gx| and dy = |py − gy|, each COORD_W bits unsigned.
    - dist² = dx² + dy², 2*COORD_W+1 bits. No truncation.
    - hit = dist² < RADIUS_SQ.
    - After idx == NUM_GHOSTS−1, go to RESOLVE.
  - RESOLVE: apply the rules below, then go to IDLE.
    - hit_mask ← scratch.
    - hit_now = |scratch.
    - Life-loss decision as given under Configuration.
    - On a loss: lives ← lives−1 and life_lost pulses for 1 cycle.
    - hit_prev ← hit_now.
- Frame edges arriving while busy are ignored; no queueing.
- Game over: once lives == 0, lives saturates at 0 and life_lost never pulses again. hit_mask keeps updating. Only Reset restores lives.
- Reset, including mid-scan: state returns to IDLE. Output values are hit_mask=0, life_lost=0, lives=LIVES, isDefeated=0, busy=0. Internal values are hit_prev=0, invuln counter=0, fc_q=0.
- Moving ghosts between frames cannot affect an in-flight scan, because evaluation uses only the snapshot.

## Timing
- Edge 0 is the Clk edge at which the frame edge is seen. Snapshot occurs at edge 0 (IDLE→SCAN).
- Ghost i is evaluated at edge 1+i.
- RESOLVE is entered at edge NUM_GHOSTS.
- Updated hit_mask, lives and life_lost are visible after edge NUM_GHOSTS+1. Latency is NUM_GHOSTS+1 cycles.
- busy is high from after edge 0 through edge NUM_GHOSTS+1.
- isDefeated is combinational from lives, so it has the same timing as lives.
- Multiplier and compare are single-cycle. If timing requires a pipeline stage, latency may grow by exactly 1 cycle. That change must be documented here.

## Configuration
- COLLISION_INVULN_EN defined:
  - A life is lost in RESOLVE when hit_now && invuln_cnt == 0 && lives != 0.
  - On each loss, invuln_cnt ← INVULN_FRAMES.
  - Otherwise, invuln_cnt decrements once per RESOLVE while nonzero.
  - A hit that persists after invulnerability expires costs another life.
- COLLISION_INVULN_EN undefined:
  - A life is lost only on a rising hit: hit_now && !hit_prev && lives != 0.
  - No counter exists; INVULN_FRAMES is unused.

## Test plan
- Single hit, defaults: ghost 1 at (100,100), pacman at (105,103), others far away; one frame edge. Required: hit_mask=3'b010 after 4 cycles, one life_lost pulse, lives=2.
- Threshold boundary: dx=8, dy=0 (dist²=64) → no hit. dx=7, dy=3 (dist²=58) → hit. Wrap check: pacman (0,0) vs ghost (1023,0) → no hit.
- Persistent overlap for 100 frames:
  - With COLLISION_INVULN_EN: losses at frame 1 and frame 62, then lives=1.
  - Without it: a single loss, lives=2.
- Game over: with LIVES=1, one hit gives lives=0 and isDefeated=1. Further hits leave lives=0 with no life_lost, while hit_mask still updates.
- Reset at SCAN idx=1: the next cycle has busy=0, lives=LIVES and hit_mask=0. The next frame edge scans normally.
- NUM_GHOSTS=8, all ghosts overlapping pacman: hit_mask=8'hFF 9 cycles after the edge. A second frame edge during busy is ignored (no restart; busy duration unchanged).
